// File: rtl/apb4_sram_if.sv
// APB4 bus bundle between a requester and the apb4_sram slave.
// The master drives the request side; the slave returns data, ready and error.
interface apb4_sram_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pready;
   logic                    pslverr;

   // Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by
   // access cycles (psel=1, penable=1); it completes on the first edge where
   // psel, penable and pready are all high. pslverr is meaningful only then.
   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb4_sram.sv
// Parametrised APB4 scratch RAM with byte strobes, programmable wait states
// and alignment/range error reporting. Two-state FSM: IDLE and ACCESS.
module apb4_sram #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic       pclk_i,
   input  logic       presetn_i,
   apb4_sram_if.slave apb_s,
   output logic [0:0] state_o,
   output logic [3:0] cnt_o
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int SH     = $clog2(STRB_W);
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << SH) - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_L    = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [3:0]            WAIT_L     = 4'(WAIT_STATES);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACCESS = 1'b1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [0:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [MEM_AW-1:0]     idx_q, idx_d;
   logic                  err_q, err_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

   logic [ADDR_WIDTH-1:0] word_addr;
   logic [MEM_AW-1:0]     mem_idx;
   logic                  misalign;
   logic                  range_err;
   logic                  addr_err;
   logic                  setup;
   logic                  pready_w;
   logic                  complete;

   // Address decode of the live bus address, used only in the setup phase.
   assign word_addr = apb_s.paddr >> SH;
   assign mem_idx   = word_addr[MEM_AW-1:0];
   assign misalign  = |(apb_s.paddr & ALIGN_MASK);
   assign range_err = {1'b0, word_addr} >= DEPTH_L;
   assign addr_err  = misalign | range_err;

   assign setup    = apb_s.psel & ~apb_s.penable;
   assign pready_w = (state_q == S_ACCESS) && (cnt_q == 4'd0);
   assign complete = pready_w & apb_s.psel & apb_s.penable;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      err_d    = err_q;
      write_d  = write_q;
      prdata_d = prdata_q;
      case (state_q)
         S_IDLE: begin
            if (setup) begin
               state_d = S_ACCESS;
               cnt_d   = WAIT_L;
               idx_d   = mem_idx;
               err_d   = addr_err;
               write_d = apb_s.pwrite;
               if (!apb_s.pwrite) begin
                  prdata_d = addr_err ? '0 : mem[mem_idx];
               end
            end
         end
         S_ACCESS: begin
            // Dropping psel mid-transfer abandons it without touching the RAM.
            if (!apb_s.psel) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (pready_w) begin
               if (apb_s.penable) begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         err_q    <= 1'b0;
         write_q  <= 1'b0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         err_q    <= err_d;
         write_q  <= write_d;
         prdata_q <= prdata_d;
      end
   end

   // RAM array is never reset; an async reset clears state_q, which blocks
   // the commit of any write still in flight.
   always_ff @(posedge pclk_i) begin
      if (complete && write_q && !err_q) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (apb_s.pstrb[b]) begin
               mem[idx_q][8*b +: 8] <= apb_s.pwdata[8*b +: 8];
            end
         end
      end
   end

   assign apb_s.prdata  = prdata_q;
   assign apb_s.pready  = pready_w;
   assign apb_s.pslverr = pready_w & err_q;

   assign state_o = state_q;
   assign cnt_o   = cnt_q;

endmodule
